// File: rtl/scarv_cpu_pshift_pkg.sv
// Shared encodings for the iterative packed shift/rotate unit.
package scarv_cpu_pshift_pkg;

    localparam logic [1:0] PSHIFT_SHL = 2'b00;
    localparam logic [1:0] PSHIFT_SHR = 2'b01;
    localparam logic [1:0] PSHIFT_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } pshift_state_t;

    // Lane width stored as log2(W).
    typedef enum logic [2:0] {
        LW_2  = 3'd1,
        LW_4  = 3'd2,
        LW_8  = 3'd3,
        LW_16 = 3'd4,
        LW_32 = 3'd5
    } lane_w_t;

    function automatic lane_w_t pw_to_lw(
        input logic pw32,
        input logic pw16,
        input logic pw8,
        input logic pw4,
        input logic pw2
    );
        if (pw32)      return LW_32;
        else if (pw16) return LW_16;
        else if (pw8)  return LW_8;
        else if (pw4)  return LW_4;
        else if (pw2)  return LW_2;
        else           return LW_32;
    endfunction

    function automatic logic [4:0] lw_mask(input lane_w_t lw);
        logic [5:0] w;
        w = 6'd1 << lw;
        return 5'(w - 6'd1);
    endfunction

endpackage

// File: rtl/scarv_cpu_pshift_stage.sv
// One fixed power-of-two shift stage applied lane-wise to 32 bits.
module scarv_cpu_pshift_stage
    import scarv_cpu_pshift_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  k_i,
    input  logic [2:0]  lw_i,
    input  logic [1:0]  op_i,
    output logic [31:0] data_o
);

    logic [5:0]  w;
    logic [5:0]  d;
    logic [5:0]  pos;
    logic [31:0] keep_lo;
    logic [31:0] keep_hi;
    logic [31:0] shl;
    logic [31:0] shr;
    logic [31:0] ror;

    always_comb begin
        w       = 6'd1 << lw_i;
        d       = 6'd1 << k_i;
        pos     = '0;
        keep_lo = '0;
        keep_hi = '0;
        // keep_lo drops bits shifted in across a lane's low edge,
        // keep_hi drops bits shifted in across its high edge.
        for (int i = 0; i < 32; i++) begin
            pos        = 6'(i) & (w - 6'd1);
            keep_lo[i] = (pos >= d);
            keep_hi[i] = (pos < (w - d));
        end
        shl = (data_i << d) & keep_lo;
        shr = (data_i >> d) & keep_hi;
        ror = shr | ((data_i << (w - d)) & ~keep_hi);
        case (op_i)
            PSHIFT_SHR: data_o = shr;
            PSHIFT_ROR: data_o = ror;
            default:    data_o = shl;
        endcase
    end

endmodule

// File: rtl/scarv_cpu_pshift_iter.sv
// Iterative packed shift/rotate: one power-of-two stage per cycle.
module scarv_cpu_pshift_iter
    import scarv_cpu_pshift_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            pw_32,
    input  logic            pw_16,
    input  logic            pw_8,
    input  logic            pw_4,
    input  logic            pw_2,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_shamt,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result
);

    pshift_state_t   state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [4:0]      shamt_q, shamt_d;
    logic [2:0]      k_q, k_d;
    logic [1:0]      op_q, op_d;
    lane_w_t         lw_q, lw_d;
    lane_w_t         req_lw;
    logic [4:0]      shamt_rem;
    logic [XLEN-1:0] stage_out;

    scarv_cpu_pshift_stage u_stage (
        .data_i (data_q),
        .k_i    (k_q),
        .lw_i   (lw_q),
        .op_i   (op_q),
        .data_o (stage_out)
    );

    assign req_lw    = pw_to_lw(pw_32, pw_16, pw_8, pw_4, pw_2);
    assign shamt_rem = shamt_q >> k_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        k_d     = k_q;
        op_d    = op_q;
        lw_d    = lw_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    data_d  = req_rs1;
                    op_d    = req_op;
                    lw_d    = req_lw;
                    shamt_d = req_shamt & lw_mask(req_lw);
                    k_d     = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (shamt_rem[0]) data_d = stage_out;
                k_d = k_q + 3'd1;
                // A zero shift still spends exactly one cycle here.
                if (shamt_rem[4:1] == 4'd0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            shamt_q <= '0;
            k_q     <= '0;
            op_q    <= PSHIFT_SHL;
            lw_q    <= LW_32;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            k_q     <= k_d;
            op_q    <= op_d;
            lw_q    <= lw_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_DONE);
    assign rsp_result = rsp_valid ? data_q : '0;

endmodule

// File: tb/tb_scarv_cpu_pshift_iter.sv
// Directed and randomized checks of the packed shift unit against a lane model.
module tb_scarv_cpu_pshift_iter;

    logic        g_clk = 1'b0;
    logic        g_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        pw_32 = 1'b0;
    logic        pw_16 = 1'b0;
    logic        pw_8  = 1'b0;
    logic        pw_4  = 1'b0;
    logic        pw_2  = 1'b0;
    logic [31:0] req_rs1 = '0;
    logic [4:0]  req_shamt = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;

    int checks = 0;
    int errors = 0;

    scarv_cpu_pshift_iter #(.XLEN(32)) dut (
        .g_clk      (g_clk),
        .g_rst      (g_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .pw_32      (pw_32),
        .pw_16      (pw_16),
        .pw_8       (pw_8),
        .pw_4       (pw_4),
        .pw_2       (pw_2),
        .req_rs1    (req_rs1),
        .req_shamt  (req_shamt),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lane_w(input logic [4:0] pw);
        if (pw[4]) return 32;
        if (pw[3]) return 16;
        if (pw[2]) return 8;
        if (pw[1]) return 4;
        if (pw[0]) return 2;
        return 32;
    endfunction

    // Lane-by-lane arithmetic reference.
    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [4:0] pw,
                                          input logic [31:0] a,
                                          input logic [4:0] sh);
        int w, s;
        logic [63:0] m, lane, r;
        logic [31:0] res;
        w = lane_w(pw);
        s = int'(sh) % w;
        m = (64'd1 << w) - 64'd1;
        res = '0;
        for (int base = 0; base < 32; base += w) begin
            lane = (64'(a) >> base) & m;
            if (op == 2'b01)      r = lane >> s;
            else if (op == 2'b10) r = ((lane >> s) | (lane << (w - s))) & m;
            else                  r = (lane << s) & m;
            res = res | 32'(r << base);
        end
        return res;
    endfunction

    function automatic int model_lat(input logic [4:0] pw,
                                     input logic [4:0] sh);
        int s, n;
        s = int'(sh) % lane_w(pw);
        n = 0;
        while (s > 0) begin
            n++;
            s = s >> 1;
        end
        return (n == 0) ? 1 : n;
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic [4:0] pw,
                             input logic [31:0] a, input logic [4:0] sh);
        req_valid = 1'b1;
        req_op    = op;
        {pw_32, pw_16, pw_8, pw_4, pw_2} = pw;
        req_rs1   = a;
        req_shamt = sh;
    endtask

    task automatic tick;
        @(posedge g_clk);
        @(negedge g_clk);
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic [4:0] pw, input logic [31:0] a,
                       input logic [4:0] sh, input int hold);
        logic [31:0] exp;
        int lat, n;
        exp = model(op, pw, a, sh);
        lat = model_lat(pw, sh);
        chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        drive_req(op, pw, a, sh);
        tick();
        req_valid = 1'b0;
        chk({tag, ".busy_result0"}, rsp_result, 32'd0);
        n = 0;
        while (!rsp_valid && n < 12) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(lat));
        chk({tag, ".result"}, rsp_result, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, ".hold_result"}, rsp_result, exp);
            chk({tag, ".hold_noready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".post_result"}, rsp_result, 32'd0);
    endtask

    task automatic no_rsp(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk({tag, ".no_rsp"}, 32'(seen), 32'd0);
    endtask

    initial begin
        @(negedge g_clk);
        tick();
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_result", rsp_result, 32'd0);
        g_rst = 1'b0;
        tick();

        run("shl32", 2'b00, 5'b10000, 32'h00000001, 5'd31, 0);
        chk("shl32.model", model(2'b00, 5'b10000, 32'h1, 5'd31), 32'h80000000);
        run("shr8", 2'b01, 5'b00100, 32'h80FF4001, 5'd3, 0);
        run("ror16", 2'b10, 5'b01000, 32'h1234ABCD, 5'd4, 1);
        run("shl4", 2'b00, 5'b00010, 32'hFFFFFFFF, 5'd6, 0);
        run("shl_nopw", 2'b00, 5'b00000, 32'hFFFFFFFF, 5'd6, 0);
        run("ror2_z", 2'b10, 5'b00001, 32'hDEADBEEF, 5'd0, 3);
        run("rsvd_op", 2'b11, 5'b00100, 32'h8001F00F, 5'd5, 0);

        // Flush in the second BUSY cycle.
        drive_req(2'b00, 5'b10000, 32'h00000001, 5'd31);
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.req_ready", 32'(req_ready), 32'd1);
        chk("flush.rsp_valid", 32'(rsp_valid), 32'd0);
        no_rsp("flush", 6);

        // Reset in mid-BUSY.
        drive_req(2'b10, 5'b10000, 32'hCAFEF00D, 5'd31);
        tick();
        req_valid = 1'b0;
        tick();
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        chk("rstbusy.req_ready", 32'(req_ready), 32'd1);
        chk("rstbusy.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstbusy.rsp_result", rsp_result, 32'd0);
        no_rsp("rstbusy", 6);

        // Request qualified by flush is dropped.
        drive_req(2'b00, 5'b10000, 32'h12345678, 5'd1);
        flush = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        chk("vflush.req_ready", 32'(req_ready), 32'd1);
        no_rsp("vflush", 4);

        for (int t = 0; t < 40; t++) begin
            run($sformatf("rnd%0d", t), 2'($urandom_range(0, 3)),
                5'($urandom), $urandom, 5'($urandom),
                int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
